arbitro_rr_3a1: RTL and testbench

- Round-robin select generator placed directly upstream of the parameterised 3-to-1 bus mux.
- Arbitrates among three data sources, drives the 2-bit select S of the mux, and presents a valid/ready handshake to the downstream consumer of the mux output Q.
- Acknowledges each source when its word has been consumed.
- Supports bounded bursts: the same source may keep the grant for up to RAFAGA consecutive transfers.

---
 rtl/arbitro_rr_3a1.sv | 166 ++++++++++++++++
 tb/tb_arbitro_rr_3a1.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_rr_3a1.sv
`default_nettype none
// ============================================================================
// Module   : arbitro_rr_3a1
// Brief    : Round-robin select generator for a 3-to-1 bus mux with bounded
//            bursts and a valid/ready handshake toward the mux consumer.
//            Optional transfer counter enabled by macro ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module arbitro_rr_3a1 #(
  parameter int unsigned RAFAGA    = 4,
  parameter int unsigned ANCHO_CNT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           req,
  input  logic                 listo,
  output logic [1:0]           S,
  output logic                 valido,
  output logic [2:0]           ack,
  output logic                 ocupado
`ifdef ARB_STATS_EN
  ,
  output logic [ANCHO_CNT-1:0] total_tx
`endif
);

  typedef enum logic [0:0] {
    REPOSO   = 1'b0,
    OTORGADO = 1'b1
  } estado_t;

  // A burst continues while cnt < RAFAGA-1, i.e. cnt+1 < RAFAGA.
  localparam logic [3:0] c_rafaga_m1 = 4'(RAFAGA - 1);

  if ((RAFAGA < 1) || (RAFAGA > 15)) begin : g_rafaga_fuera_rango
    $error("arbitro_rr_3a1: RAFAGA must be within 1..15");
  end

  if (ANCHO_CNT < 1) begin : g_ancho_fuera_rango
    $error("arbitro_rr_3a1: ANCHO_CNT must be at least 1");
  end

  estado_t    estado_q, estado_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ultimo_q, ultimo_d;
  logic       valido_q, valido_d;
  logic       ocupado_q, ocupado_d;
  logic [3:0] cnt_q, cnt_d;

  logic [2:0] w_sel_oh;
  logic       w_transfer;
  logic       w_req_sel;

  // Winner search starts one past the last served source and wraps mod 3.
  function automatic logic [1:0] f_ganador(input logic [2:0] r, input logic [1:0] ult);
    logic [1:0] g;
    g = 2'd0;
    case (ult)
      2'd0: begin
        if (r[1])      g = 2'd1;
        else if (r[2]) g = 2'd2;
        else           g = 2'd0;
      end
      2'd1: begin
        if (r[2])      g = 2'd2;
        else if (r[0]) g = 2'd0;
        else           g = 2'd1;
      end
      default: begin
        if (r[0])      g = 2'd0;
        else if (r[1]) g = 2'd1;
        else           g = 2'd2;
      end
    endcase
    return g;
  endfunction

  assign w_sel_oh   = {sel_q == 2'd2, sel_q == 2'd1, sel_q == 2'd0};
  assign w_transfer = valido_q & listo;
  assign w_req_sel  = |(req & w_sel_oh);

  assign ack     = {3{w_transfer}} & w_sel_oh;
  assign S       = sel_q;
  assign valido  = valido_q;
  assign ocupado = ocupado_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q  <= REPOSO;
      sel_q     <= 2'd0;
      ultimo_q  <= 2'd2;
      valido_q  <= 1'b0;
      ocupado_q <= 1'b0;
      cnt_q     <= 4'd0;
    end else begin
      estado_q  <= estado_d;
      sel_q     <= sel_d;
      ultimo_q  <= ultimo_d;
      valido_q  <= valido_d;
      ocupado_q <= ocupado_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    estado_d  = estado_q;
    sel_d     = sel_q;
    ultimo_d  = ultimo_q;
    valido_d  = valido_q;
    ocupado_d = ocupado_q;
    cnt_d     = cnt_q;
    case (estado_q)
      REPOSO: begin
        if (req != 3'b000) begin
          sel_d     = f_ganador(req, ultimo_q);
          valido_d  = 1'b1;
          ocupado_d = 1'b1;
          cnt_d     = 4'd0;
          estado_d  = OTORGADO;
        end
      end
      OTORGADO: begin
        if (w_transfer) begin
          ultimo_d = sel_q;
          if (w_req_sel && (cnt_q < c_rafaga_m1)) begin
            cnt_d = cnt_q + 4'd1;
          end else if (req != 3'b000) begin
            // Rotation with no bubble; a lone requester simply re-wins.
            sel_d = f_ganador(req, sel_q);
            cnt_d = 4'd0;
          end else begin
            valido_d  = 1'b0;
            ocupado_d = 1'b0;
            cnt_d     = 4'd0;
            estado_d  = REPOSO;
          end
        end else if (!w_req_sel) begin
          // Source withdrew during a stall: drop the grant, keep ultimo.
          valido_d  = 1'b0;
          ocupado_d = 1'b0;
          cnt_d     = 4'd0;
          estado_d  = REPOSO;
        end
      end
      default: begin
        estado_d = REPOSO;
      end
    endcase
  end

`ifdef ARB_STATS_EN
  logic [ANCHO_CNT-1:0] total_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      total_q <= '0;
    end else if (w_transfer && (total_q != {ANCHO_CNT{1'b1}})) begin
      total_q <= total_q + ANCHO_CNT'(1);
    end
  end

  assign total_tx = total_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_arbitro_rr_3a1.sv
`default_nettype none
// Testbench for arbitro_rr_3a1: directed scenarios plus randomized traffic
// checked against a behavioural round-robin model.
module tb_arbitro_rr_3a1;

  localparam int RAF     = 4;
  localparam int ANCHO   = 4;
  localparam int TOT_MAX = (1 << ANCHO) - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic       listo;
  logic [1:0] S;
  logic       valido;
  logic [2:0] ack;
  logic       ocupado;
`ifdef ARB_STATS_EN
  logic [ANCHO-1:0] total_tx;
`endif

  arbitro_rr_3a1 #(.RAFAGA(RAF), .ANCHO_CNT(ANCHO)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .listo   (listo),
    .S       (S),
    .valido  (valido),
    .ack     (ack),
    .ocupado (ocupado)
`ifdef ARB_STATS_EN
    ,
    .total_tx(total_tx)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int pending [3];
  int waitn   [3];
  int m_owner, m_last, m_run, m_tot;
  bit m_init = 1'b0;
  int t3_exp [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};

  logic [2:0] obs_ack;
  logic [1:0] obs_s;
  logic       obs_v, obs_o;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [2:0] r, input int last);
    for (int k = 1; k <= 3; k++)
      if (r[(last + k) % 3]) return (last + k) % 3;
    return -1;
  endfunction

  task automatic model_step(input logic [2:0] r, input logic l, input logic rs);
    if (rs) begin
      m_owner = -1; m_last = 2; m_run = 0; m_tot = 0; m_init = 1'b1;
      for (int j = 0; j < 3; j++) waitn[j] = 0;
      return;
    end
    if (!m_init) return;
    if (m_owner < 0) begin
      if (r != 3'b000) begin
        m_owner = pick(r, m_last);
        m_run   = 0;
      end
    end else if (l) begin
      for (int j = 0; j < 3; j++) begin
        if (!r[j]) waitn[j] = 0;
        else if (j != m_owner) begin
          waitn[j]++;
          chk("starvation_bound", 32'(waitn[j] <= 2 * RAF), 32'd1);
        end
      end
      if (m_tot < TOT_MAX) m_tot++;
      m_last = m_owner;
      m_run++;
      if (!(r[m_owner] && m_run < RAF)) begin
        m_owner = (r != 3'b000) ? pick(r, m_last) : -1;
        m_run   = 0;
      end
    end else if (!r[m_owner]) begin
      m_owner = -1;
    end
    if (m_owner >= 0) waitn[m_owner] = 0;
  endtask

  task automatic step(input logic l, input logic rs);
    listo = l;
    rst   = rs;
    #1;
    obs_ack = ack; obs_s = S; obs_v = valido; obs_o = ocupado;
    if (m_init) begin
      chk("valido", 32'(valido), 32'(m_owner >= 0));
      chk("ocupado", 32'(ocupado), 32'(m_owner >= 0));
      if (m_owner >= 0) chk("S", 32'(S), 32'(m_owner));
      chk("ack", 32'(ack), (m_owner >= 0 && l) ? 32'(1 << m_owner) : 32'd0);
`ifdef ARB_STATS_EN
      chk("total_tx", 32'(total_tx), 32'(m_tot));
`endif
    end
    if (m_init && !rs && m_owner >= 0 && l && pending[m_owner] > 0) pending[m_owner]--;
    for (int i = 0; i < 3; i++) req[i] = (pending[i] > 0);
    @(posedge clk);
    model_step(req, l, rs);
    #1;
  endtask

  initial begin
    logic l_r, rs_r;
    rst = 1'b1; req = 3'b000; listo = 1'b0;
    for (int i = 0; i < 3; i++) begin pending[i] = 0; waitn[i] = 0; end
    m_owner = -1; m_last = 2; m_run = 0; m_tot = 0;

    // Reset, then idle with no requests
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 1'b0);
      chk("t1_S", 32'(obs_s), 32'd0);
      chk("t1_valido", 32'(obs_v), 32'd0);
      chk("t1_ack", 32'(obs_ack), 32'd0);
      chk("t1_ocupado", 32'(obs_o), 32'd0);
    end

    // Three single-word requesters: back-to-back rotation
    pending = '{1, 1, 1};
    step(1'b1, 1'b0);
    step(1'b1, 1'b0); chk("t2_ack0", 32'(obs_ack), 32'b001); chk("t2_s0", 32'(obs_s), 32'd0);
    step(1'b1, 1'b0); chk("t2_ack1", 32'(obs_ack), 32'b010); chk("t2_s1", 32'(obs_s), 32'd1);
    step(1'b1, 1'b0); chk("t2_ack2", 32'(obs_ack), 32'b100); chk("t2_s2", 32'(obs_s), 32'd2);
    step(1'b1, 1'b0); chk("t2_idle", 32'(obs_v), 32'd0);

    // Bursts of RAFAGA with two continuous requesters
    pending[0] = 1000; pending[1] = 1000;
    step(1'b1, 1'b0);
    for (int c = 0; c < 9; c++) begin
      step(1'b1, 1'b0);
      chk("t3_S", 32'(obs_s), 32'(t3_exp[c]));
      chk("t3_ack", 32'(obs_ack), 32'(1 << t3_exp[c]));
    end
    pending[0] = 0; pending[1] = 0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0); chk("t3_idle", 32'(obs_v), 32'd0);

    // Stall: grant must hold steady while listo=0
    pending[2] = 1;
    step(1'b0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 1'b0);
      chk("t4_S", 32'(obs_s), 32'd2);
      chk("t4_valido", 32'(obs_v), 32'd1);
      chk("t4_ack", 32'(obs_ack), 32'd0);
    end
    step(1'b1, 1'b0); chk("t4_ack_release", 32'(obs_ack), 32'b100);
    step(1'b0, 1'b0); chk("t4_idle", 32'(obs_v), 32'd0);

    // Reset while granted to source 1
    pending[1] = 1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0); chk("t5_granted", 32'(obs_s), 32'd1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("t5_rst_valido", 32'(obs_v), 32'd0);
    chk("t5_rst_S", 32'(obs_s), 32'd0);
    chk("t5_rst_ack", 32'(obs_ack), 32'd0);
    step(1'b1, 1'b0);
    chk("t5_regrant_S", 32'(obs_s), 32'd1);
    chk("t5_regrant_ack", 32'(obs_ack), 32'b010);
    step(1'b0, 1'b0);

    // Protocol violation: req drops during a stall; ultimo stays at 1
    pending[0] = 3;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0); chk("t7_S", 32'(obs_s), 32'd0);
    pending[0] = 0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("t7_drop_valido", 32'(obs_v), 32'd0);
    chk("t7_drop_ack", 32'(obs_ack), 32'd0);
    pending[0] = 1; pending[1] = 1;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0); chk("t7_after_S", 32'(obs_s), 32'd0); chk("t7_after_ack", 32'(obs_ack), 32'b001);
    step(1'b1, 1'b0); chk("t7_next_ack", 32'(obs_ack), 32'b010);
    step(1'b1, 1'b0);

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 3; i++)
        if (pending[i] == 0 && $urandom_range(0, 3) == 0) pending[i] = int'($urandom_range(1, 7));
      rs_r = ($urandom_range(0, 199) == 0);
      l_r  = rs_r ? 1'b0 : ($urandom_range(0, 3) != 0);
      step(l_r, rs_r);
    end

`ifdef ARB_STATS_EN
    // Transfer counter saturation
    for (int i = 0; i < 3; i++) pending[i] = 0;
    step(1'b0, 1'b1);
    pending[0] = 30;
    step(1'b1, 1'b0);
    for (int c = 0; c < 20; c++) begin
      step(1'b1, 1'b0);
      chk("t6_total", 32'(total_tx), 32'((c + 1 > TOT_MAX) ? TOT_MAX : c + 1));
    end
    pending[0] = 0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
